// File: rtl/kanade32_pkg.sv
// kanade32_pkg: shared types and constants for the kanade32 RAM arbiter.
//   RAM_DEPTH : number of words in the shared single-port RAM
//   resp_t    : tag of the read response due in the next cycle
//   port_t    : requester identity, also used as the round-robin pointer
package kanade32_pkg;
    localparam int RAM_DEPTH = 1024;
    typedef enum logic [1:0] {RESP_NONE, RESP_I, RESP_D} resp_t;
    typedef enum logic {PORT_I, PORT_D} port_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of the fetch port, data port and RAM-side signals.
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata                  fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata     load/store port
//   ram_wren/ram_address/ram_data -> RAM, ram_q <- RAM      RAM side
//   modport slave  : the arbiter's view
//   modport master : the view of the environment around the arbiter
interface ram_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_q,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               ram_wren, ram_address, ram_data
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_q,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               ram_wren, ram_address, ram_data
    );
endinterface

// File: rtl/ram_arbiter_arb2.sv
// arb2_rr: two-requester grant unit (bit 0 = fetch port, bit 1 = data port).
//   req[1:0]  in  active requests
//   prio      in  port that wins when both request
//   gnt[1:0]  out one-hot grant (or zero when idle)
//   prio_nxt  out pointer after this cycle: the loser of a conflict, else prio
// A lone requester always wins; prio only decides conflicts.
module arb2_rr
    import kanade32_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      prio,
    output logic [1:0] gnt,
    output port_t      prio_nxt
);
    logic both;

    assign both = &req;

    always_comb begin
        gnt      = both ? ((prio == PORT_D) ? 2'b10 : 2'b01) : req;
        prio_nxt = both ? ((prio == PORT_D) ? PORT_I : PORT_D) : prio;
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the fetch (I) and data (D) ports.
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    ram_arbiter_if.slave: request/grant/response ports and RAM lines
// Build option RAM_ARB_RR_EN: when defined, conflicts are resolved round-robin;
// otherwise D always beats I and no priority register exists.
// Reads return on ram_q one cycle after the grant; the resp tag remembers
// which port that data belongs to.
module ram_arbiter
    import kanade32_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
)(
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);
    logic [1:0]        req;
    logic [1:0]        gnt_raw;
    logic [1:0]        gnt;
    port_t             prio;
    port_t             prio_nxt;
    resp_t             resp;
    resp_t             resp_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;

    assign req = {bus.d_req, bus.i_req};

    arb2_rr u_arb (
        .req      (req),
        .prio     (prio),
        .gnt      (gnt_raw),
        .prio_nxt (prio_nxt)
    );

    // Grants are combinational, so they must be masked while reset is held.
    assign gnt = rst_n ? gnt_raw : 2'b00;

`ifdef RAM_ARB_RR_EN
    // prio_nxt already equals prio unless both ports requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio <= PORT_D;
        else
            prio <= prio_nxt;
    end
`else
    logic unused_prio;

    assign prio        = PORT_D;
    assign unused_prio = prio_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            resp <= RESP_NONE;
        else
            resp <= resp_nxt;
    end

    // Stores produce no response.
    always_comb
        resp_nxt = gnt[0] ? RESP_I : (gnt[1] && !bus.d_we) ? RESP_D : RESP_NONE;

    // With no winner the fetch address is presented anyway.
    assign addr  = gnt[1] ? bus.d_addr : bus.i_addr;
    assign rdata = bus.ram_q;

    assign bus.i_gnt       = gnt[0];
    assign bus.d_gnt       = gnt[1];
    assign bus.ram_wren    = gnt[1] & bus.d_we;
    assign bus.ram_address = addr;
    assign bus.ram_data    = bus.d_wdata;
    assign bus.i_rvalid    = (resp == RESP_I);
    assign bus.d_rvalid    = (resp == RESP_D);
    assign bus.i_rdata     = rdata;
    assign bus.d_rdata     = rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with a behavioural RAM.
module tb_ram_arbiter;
    import kanade32_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int W_NONE = 0;
    localparam int W_I = 1;
    localparam int W_D = 2;

    typedef struct {
        resp_t         tag;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   sb_on = 1'b0;
    exp_t sb[$];

    logic [DW-1:0] mem [RAM_DEPTH];
    logic [DW-1:0] ref_mem [RAM_DEPTH];

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Registered-output single-port RAM: write and read land at the same edge.
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_address[9:0]] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_address[9:0]];
    end

    // Scoreboard: each cycle pops the response expected from the previous grant.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_on && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks += 2;
            if (bus.i_rvalid !== (e.tag == RESP_I)) begin
                n_fail++;
                $display("FAIL i_rvalid at %0t: got %b want %b", $time, bus.i_rvalid, e.tag == RESP_I);
            end
            if (bus.d_rvalid !== (e.tag == RESP_D)) begin
                n_fail++;
                $display("FAIL d_rvalid at %0t: got %b want %b", $time, bus.d_rvalid, e.tag == RESP_D);
            end
            if (e.tag == RESP_I) begin
                n_checks++;
                if (bus.i_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL i_rdata at %0t: got %h want %h", $time, bus.i_rdata, e.data);
                end
            end
            if (e.tag == RESP_D) begin
                n_checks++;
                if (bus.d_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL d_rdata at %0t: got %h want %h", $time, bus.d_rdata, e.data);
                end
            end
        end
    end

    // Drives one cycle of requests and queues the response the expected winner implies.
    task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                         input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                         input int exp_w);
        bus.i_req = ir;
        bus.i_addr = ia;
        bus.d_req = dr;
        bus.d_we = dw;
        bus.d_addr = da;
        bus.d_wdata = wd;
        if (exp_w == W_I)
            sb.push_back('{RESP_I, ref_mem[ia[9:0]]});
        else if (exp_w == W_D && !dw)
            sb.push_back('{RESP_D, ref_mem[da[9:0]]});
        else begin
            if (exp_w == W_D) ref_mem[da[9:0]] = wd;
            sb.push_back('{RESP_NONE, '0});
        end
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, W_NONE);
        next();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        sb.delete();
        sb.push_back('{RESP_NONE, '0});
        sb_on = 1'b1;
    endtask

    task automatic do_reset();
        sb_on = 1'b0;
        rst_n = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        release_reset();
    endtask

    task automatic test_reset();
        sb_on = 1'b0;
        rst_n = 1'b0;
        bus.i_req = 1'b1;
        bus.i_addr = 30'h1;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 30'h2;
        bus.d_wdata = 32'h1234_5678;
        @(negedge clk);
        n_checks += 3;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b want 00", {bus.d_gnt, bus.i_gnt});
        end
        if (bus.ram_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wren: got %b want 0", bus.ram_wren);
        end
        if ({bus.d_rvalid, bus.i_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_rvalid: got %b want 00", {bus.d_rvalid, bus.i_rvalid});
        end
        next();
        release_reset();
        drive(1'b1, 30'h1, 1'b1, 1'b0, 30'h2, '0, W_D);
        n_checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL first_conflict_gnt: got %b want 10", {bus.d_gnt, bus.i_gnt});
        end
        next();
        idle();
    endtask

    task automatic test_single_fetch();
        drive(1'b1, 30'h4, 1'b0, 1'b0, '0, '0, W_I);
        n_checks += 2;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL fetch_gnt: got %b want 01", {bus.d_gnt, bus.i_gnt});
        end
        if (bus.ram_address !== 30'h4) begin
            n_fail++;
            $display("FAIL fetch_addr: got %h want 4", bus.ram_address);
        end
        next();
        idle();
    endtask

    task automatic test_store_load();
        drive(1'b0, 30'h3, 1'b1, 1'b1, 30'h10, 32'hDEAD_BEEF, W_D);
        n_checks += 4;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL store_gnt: got %b want 10", {bus.d_gnt, bus.i_gnt});
        end
        if (bus.ram_wren !== 1'b1) begin
            n_fail++;
            $display("FAIL store_wren: got %b want 1", bus.ram_wren);
        end
        if (bus.ram_address !== 30'h10) begin
            n_fail++;
            $display("FAIL store_addr: got %h want 10", bus.ram_address);
        end
        if (bus.ram_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL store_data: got %h want deadbeef", bus.ram_data);
        end
        next();
        drive(1'b0, 30'h3, 1'b1, 1'b0, 30'h10, '0, W_D);
        n_checks += 2;
        if (bus.d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL load_gnt: got %b want 1", bus.d_gnt);
        end
        if (bus.ram_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL load_wren: got %b want 0", bus.ram_wren);
        end
        next();
        idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, AW'(8 + k), 1'b0, 1'b0, '0, '0, W_I);
            n_checks++;
            if ({bus.d_gnt, bus.i_gnt} !== 2'b01) begin
                n_fail++;
                $display("FAIL b2b_fetch_gnt[%0d]: got %b want 01", k, {bus.d_gnt, bus.i_gnt});
            end
            next();
        end
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                drive(1'b1, AW'(100 + k), 1'b0, 1'b0, '0, '0, W_I);
            else
                drive(1'b0, '0, 1'b1, 1'b0, AW'(200 + k), '0, W_D);
            n_checks++;
            if ({bus.d_gnt, bus.i_gnt} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL b2b_mixed_gnt[%0d]: got %b", k, {bus.d_gnt, bus.i_gnt});
            end
            next();
        end
        idle();
    endtask

    task automatic test_contention();
        logic [1:0] want;
        do_reset();
`ifdef RAM_ARB_RR_EN
        for (int k = 0; k < 6; k++) begin
            want = (k % 2 == 0) ? 2'b10 : 2'b01;
            drive(1'b1, AW'(20 + k), 1'b1, 1'b0, AW'(40 + k), '0, (k % 2 == 0) ? W_D : W_I);
`else
        for (int k = 0; k < 4; k++) begin
            want = 2'b10;
            drive(1'b1, AW'(20 + k), 1'b1, 1'b0, AW'(40 + k), '0, W_D);
`endif
            n_checks++;
            if ({bus.d_gnt, bus.i_gnt} !== want) begin
                n_fail++;
                $display("FAIL contention_gnt[%0d]: got %b want %b", k, {bus.d_gnt, bus.i_gnt}, want);
            end
            next();
        end
        idle();
    endtask

    task automatic test_single_wins();
        do_reset();
        drive(1'b1, 30'h30, 1'b1, 1'b0, 30'h31, '0, W_D);
        next();
        drive(1'b0, '0, 1'b1, 1'b0, 30'h32, '0, W_D);
        n_checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL lone_d_gnt: got %b want 10", {bus.d_gnt, bus.i_gnt});
        end
        next();
        drive(1'b1, 30'h33, 1'b0, 1'b0, '0, '0, W_I);
        n_checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL lone_i_gnt: got %b want 01", {bus.d_gnt, bus.i_gnt});
        end
        next();
`ifdef RAM_ARB_RR_EN
        drive(1'b1, 30'h34, 1'b1, 1'b0, 30'h35, '0, W_I);
        n_checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL second_conflict_gnt: got %b want 01", {bus.d_gnt, bus.i_gnt});
        end
`else
        drive(1'b1, 30'h34, 1'b1, 1'b0, 30'h35, '0, W_D);
        n_checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL second_conflict_gnt: got %b want 10", {bus.d_gnt, bus.i_gnt});
        end
`endif
        next();
        idle();
    endtask

    task automatic test_reset_mid_read();
        drive(1'b0, '0, 1'b1, 1'b0, 30'h10, '0, W_D);
        n_checks++;
        if (bus.d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midread_gnt: got %b want 1", bus.d_gnt);
        end
        sb_on = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.d_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_gnt_in_reset: got %b want 0", bus.d_gnt);
        end
        next();
        n_checks++;
        if (bus.d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_rvalid_in_reset: got %b want 0", bus.d_rvalid);
        end
        next();
        release_reset();
        idle();
        idle();
        drive(1'b0, '0, 1'b1, 1'b0, 30'h10, '0, W_D);
        next();
        idle();
    endtask

    initial begin
        for (int k = 0; k < RAM_DEPTH; k++) begin
            mem[k] <= 32'(k) * 32'h9E37_79B9;
            ref_mem[k] = 32'(k) * 32'h9E37_79B9;
        end
        mem[4] <= 32'h2008_0005;
        ref_mem[4] = 32'h2008_0005;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_back_to_back();
        test_contention();
        test_single_wins();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port, 1024-word RAM between the CPU instruction-fetch port (I) and the load/store data port (D). Grants at most one access per cycle, drives the RAM address, write-enable and write-data lines, and routes the registered read data back to the port that issued the read one cycle later. It sits between the kanade32 core and the RAM.

## Interface
Parameters:
- ADDR_W, 30, word address width (the RAM is word-addressed)
- DATA_W, 32, data width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch granted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid (registered)
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access granted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid, loads only (registered)
- d_rdata  out  DATA_W  load data
- ram_wren  out  1  to RAM wren
- ram_address  out  ADDR_W  to RAM address
- ram_data  out  DATA_W  to RAM data
- ram_q  in  DATA_W  from RAM q

## Operation
- Each cycle, choose a winner from the active requests: none, I, or D. Assert the winner's gnt only.
- Drive ram_address from the winner. With no winner, drive ram_address from the I port.
- ram_wren = d_gnt & d_we. ram_data = d_wdata at all times.
- Response tag register `resp` with values {NONE, I, D}:
  - Next value is I when i_gnt.
  - Next value is D when d_gnt & ~d_we.
  - Otherwise NONE.
- i_rvalid = (resp==I); d_rvalid = (resp==D). Both rdata outputs are driven from ram_q.
- Priority pointer `prio` with values {I, D}. It updates only when i_req and d_req are both high in the same cycle: the loser gets priority for the next cycle.
- A single requester always wins, whatever the value of prio.
- Read-after-write to the same address in back-to-back grants returns the new data, because the RAM write lands at the grant edge.
- A requester may raise req in the cycle its previous rvalid arrives. Full throughput is one access per cycle.
- Requests must not be withdrawn before gnt. The arbiter does not check this.

## Timing
- Reset values: resp=NONE, prio=D, i_rvalid=0, d_rvalid=0.
- While rst_n=0, i_gnt, d_gnt and ram_wren are forced to 0.
- Read latency: gnt in cycle N, then rvalid and data in cycle N+1. The data is held only for that cycle.
- Write: the data is committed at the rising edge that ends the gnt cycle. There is no rvalid for a write.
- Simultaneous requests: exactly one gnt. The loser keeps its req and wins in the next cycle if it still conflicts.
- Reset asserted while a read is in flight: resp clears immediately and the response is dropped. The requester re-issues after reset.
- Worst-case wait under continuous contention is 1 cycle.

## Configuration
- RAM_ARB_RR_EN defined: round-robin behaviour using prio, as described above.
- RAM_ARB_RR_EN undefined: fixed priority, D always beats I. The prio register is not built, and the fetch port can starve.

## Structure
- Shared package kanade32_pkg holds:
  - the response-tag enum (RESP_NONE, RESP_I, RESP_D);
  - the port-id enum (PORT_I, PORT_D);
  - the RAM_DEPTH constant of 1024.
- One sub-module is natural: arb2_rr, a two-requester round-robin/fixed-priority grant unit. It takes (req[1:0], prio) and produces gnt[1:0] plus the next value of prio. The top level holds the RAM mux and the response tag.

## Test plan
- Reset: rst_n=0 with i_req=d_req=1 -> i_gnt=d_gnt=ram_wren=0, both rvalid=0. After release, the first conflict grants D.
- Single fetch: i_req, i_addr=0x4, RAM[4]=0x20080005 -> i_gnt in the same cycle, then i_rvalid=1 with i_rdata=0x20080005 in the next cycle and d_rvalid=0.
- Store then load: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, then a load from 0x10 on the next cycle -> ram_wren pulses for one cycle, and d_rdata=0xDEADBEEF one cycle after the load grant.
- Continuous contention with RAM_ARB_RR_EN: both requests held for 6 cycles -> grants alternate D,I,D,I,D,I, and each rvalid is tagged to the correct port.
- Contention without RAM_ARB_RR_EN: both requests held for 4 cycles -> D is granted in all 4 cycles and i_gnt stays 0.
- Reset mid-read: d read granted at cycle N and rst_n=0 at cycle N+1 before the edge -> d_rvalid never asserts, and resp=NONE after release.
